yags_branch_predictor: RTL and testbench
========================================

Name: yags_branch_predictor

Overview:
- YAGS direction predictor, upstream of the EX-stage branch-mux signal generator.
- Looks up a base PHT plus taken/not-taken tagged exception caches for the fetch PC in IF. Emits PHT_prediction_IF and YAGS_prediction_IF, which the pipeline carries to EX as PHT_prediction_EX / YAGS_prediction_EX.
- Trains on resolved conditional branches in EX and keeps synthesizable mispredict counters.

Parameters:
- PHT_IDX_BITS, 10, log2 of base-PHT entries (2-bit counters).
- CACHE_IDX_BITS, 8, log2 of entries per exception cache.
- TAG_BITS, 6, partial PC tag width per cache entry.
- GHR_BITS, 8, global history length (must be <= CACHE_IDX_BITS).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- pc_IF  input  32  fetch PC.
- PHT_prediction_IF  output  1  base PHT counter MSB.
- YAGS_prediction_IF  output  1  final predicted direction.
- pred_meta_IF  output  CACHE_IDX_BITS+2  {base_pred, cache_hit, cache_idx}; piped to EX with the instruction.
- branch_signal  input  1  EX holds a resolved conditional branch; update strobe.
- actual_prediction  input  1  resolved direction (1 = taken).
- pc_EX  input  32  PC of the resolving branch.
- pred_meta_EX  input  CACHE_IDX_BITS+2  meta carried from IF.
- stall_EX  input  1  EX held; suppresses training.
- branch_count  output  32  resolved branches, saturating.
- mispredict_count  output  32  YAGS mispredicts, saturating.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All PHT counters = 2'b01 (weakly not-taken).
  - Both caches: valid=0.
  - GHR=0; both counters=0.
  - Consequently, after reset with no training, PHT_prediction_IF=0, YAGS_prediction_IF=0, pred_meta_IF={0,0,idx}.
  - Reset overrides a same-cycle update.
- Lookup (combinational, 0-cycle latency):
  - pht_idx = pc_IF[PHT_IDX_BITS+1:2]; base = PHT[pht_idx][1].
  - cache_idx = pc_IF[CACHE_IDX_BITS+1:2] XOR zero-extended GHR.
  - tag = pc_IF[TAG_BITS+1:2].
  - base=1 consults the NT cache; base=0 consults the T cache.
  - hit = entry valid and tag match. YAGS_prediction_IF = hit ? entry.ctr[1] : base.
- Update (registered, effective at the rising edge where branch_signal=1 and stall_EX=0):
  - Recompute pht_idx and tag from pc_EX. Take base, hit and cache_idx from pred_meta_EX (never recomputed from the current GHR).
  - Consulted cache: NT if base=1, else T. yags = hit ? consulted ctr[1] : base.
  - PHT counter saturating ±1 toward actual_prediction, EXCEPT when hit=1, yags==actual and base!=actual: then the PHT is left unchanged.
  - Cache entry training:
    - hit=1: saturating ±1 toward actual.
    - hit=0 and base!=actual: allocate into the consulted cache with valid=1, tag=tag, ctr = actual ? 2'b10 : 2'b01.
    - hit=0 and base==actual: no cache write.
  - GHR <= {GHR[GHR_BITS-2:0], actual_prediction}.
  - branch_count += 1. mispredict_count += 1 if yags != actual. Both hold at 32'hFFFF_FFFF.
- Simultaneous lookup and update to the same PHT or cache entry: the lookup returns the pre-update value. The new value is visible the following cycle. No bypass.
- Saturating counters: 2'b11 + taken stays 2'b11; 2'b00 + not-taken stays 2'b00.
- Only the consulted cache is written per update. The other cache is untouched, even on a tag match there.
- Inputs during reset are ignored. No X-propagation from unwritten cache entries (valid=0 masks them).

Decomposition:
- Package yags_pkg:
  - cache_entry_t struct {valid, tag, ctr[1:0]}.
  - yags_meta_t struct {base_pred, cache_hit, cache_idx}.
  - Counter reset constants CTR_WNT=2'b01, CTR_WT=2'b10.
  - Function sat_ctr_update(ctr, taken).
- One sub-module: yags_tag_cache, instantiated twice (T and NT). It contains the entry array, combinational read/hit port, a registered write/allocate port and the synchronous valid clear.
- Top-level holds the PHT, GHR, update decision logic and perf counters.

Test Plan:
- Reset then pc_IF=32'h0000_0100 -> PHT_prediction_IF=0, YAGS_prediction_IF=0, cache_hit=0; branch_count=0.
- Four taken updates at pc_EX=32'h100 with meta base=0/hit=0:
  - 1st update: T-cache alloc ctr=2'b10, PHT 01->10.
  - Next lookup with matching GHR-derived idx: base=1, consults NT cache, miss -> YAGS_prediction_IF=1.
  - Remaining updates: PHT saturates at 11.
- Base=1 PHT entry, NT-cache entry ctr=01 hit, actual=0 -> YAGS predicts 0 and is correct. PHT unchanged (still 11); NT ctr -> 00; mispredict_count unchanged.
- Update and lookup to the same pc/idx in the same cycle -> lookup shows the old counter; the following cycle shows the new one.
- stall_EX=1 with branch_signal=1 -> no PHT/cache/GHR/counter change. Deassert stall -> exactly one update applied.
- Force mispredict_count to 32'hFFFF_FFFF, apply a mispredict -> stays 32'hFFFF_FFFF. Pulse rst_n=0 mid-stream -> all counters 0, GHR 0, all caches invalid.

Source files
------------

// File: rtl/yags_pkg.sv
// yags_pkg: shared sizes, entry/meta types and saturating-counter helper for the YAGS predictor
package yags_pkg;
  localparam int PHT_IDX_BITS = 10;
  localparam int CACHE_IDX_BITS = 8;
  localparam int TAG_BITS = 6;
  localparam int GHR_BITS = 8;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  typedef struct packed {
    logic valid;
    logic [TAG_BITS-1:0] tag;
    logic [1:0] ctr;
  } cache_entry_t;
  typedef struct packed {
    logic base_pred;
    logic cache_hit;
    logic [CACHE_IDX_BITS-1:0] cache_idx;
  } yags_meta_t;
  function automatic logic [1:0] sat_ctr_update(input logic [1:0] ctr, input logic taken);
    return taken ? ((ctr == 2'b11) ? ctr : ctr + 2'd1) : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
  endfunction
endpackage

// File: rtl/yags_branch_predictor_if.sv
// yags_branch_predictor_if: IF lookup, EX training and perf-counter signals of the YAGS predictor
interface yags_branch_predictor_if;
  logic [31:0] pc_IF;
  logic PHT_prediction_IF;
  logic YAGS_prediction_IF;
  yags_pkg::yags_meta_t pred_meta_IF;
  logic branch_signal;
  logic actual_prediction;
  logic [31:0] pc_EX;
  yags_pkg::yags_meta_t pred_meta_EX;
  logic stall_EX;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  modport master (
    output pc_IF, branch_signal, actual_prediction, pc_EX, pred_meta_EX, stall_EX,
    input PHT_prediction_IF, YAGS_prediction_IF, pred_meta_IF, branch_count, mispredict_count
  );
  modport slave (
    input pc_IF, branch_signal, actual_prediction, pc_EX, pred_meta_EX, stall_EX,
    output PHT_prediction_IF, YAGS_prediction_IF, pred_meta_IF, branch_count, mispredict_count
  );
endinterface

// File: rtl/yags_tag_cache.sv
// yags_tag_cache: tagged 2-bit-counter exception cache with combinational lookup and registered train/allocate
module yags_tag_cache
  import yags_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic [CACHE_IDX_BITS-1:0] rd_idx,
  input  logic [TAG_BITS-1:0] rd_tag,
  output logic rd_hit,
  output logic [1:0] rd_ctr,
  input  logic wr_en,
  input  logic wr_alloc,
  input  logic [CACHE_IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic wr_taken,
  output logic [1:0] wr_ctr
);
  localparam int N = 1 << CACHE_IDX_BITS;
  cache_entry_t mem_q [N];
  cache_entry_t wr_entry;
  always_comb begin
    rd_hit = mem_q[rd_idx].valid && (mem_q[rd_idx].tag == rd_tag);
    rd_ctr = mem_q[rd_idx].ctr;
    wr_ctr = mem_q[wr_idx].ctr;
    wr_entry = '{valid: 1'b1, tag: wr_tag,
                 ctr: wr_alloc ? (wr_taken ? CTR_WT : CTR_WNT) : sat_ctr_update(wr_ctr, wr_taken)};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i].valid <= 1'b0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end
endmodule

// File: rtl/yags_branch_predictor.sv
// yags_branch_predictor: YAGS direction predictor with base PHT, T/NT exception caches, GHR and perf counters
module yags_branch_predictor
  import yags_pkg::*;
(
  input logic clk,
  input logic rst_n,
  yags_branch_predictor_if.slave bus
);
  localparam int PHT_N = 1 << PHT_IDX_BITS;
  logic [1:0] pht_q [PHT_N];
  logic [1:0] pht_d;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [PHT_IDX_BITS-1:0] if_pht_idx, ex_pht_idx;
  logic [CACHE_IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic if_base, if_hit, t_hit, nt_hit, upd, act, ex_yags, pht_wr, cache_wr;
  logic [1:0] t_ctr, nt_ctr, t_ex_ctr, nt_ex_ctr, ex_ctr;
  yags_meta_t ex_meta;
  logic unused;
  assign unused = ^{bus.pc_IF[31:PHT_IDX_BITS+2], bus.pc_IF[1:0], bus.pc_EX[31:PHT_IDX_BITS+2], bus.pc_EX[1:0]};
  always_comb begin
    if_pht_idx = bus.pc_IF[PHT_IDX_BITS+1:2];
    if_idx = bus.pc_IF[CACHE_IDX_BITS+1:2] ^ CACHE_IDX_BITS'(ghr_q);
    if_tag = bus.pc_IF[TAG_BITS+1:2];
    if_base = pht_q[if_pht_idx][1];
    if_hit = if_base ? nt_hit : t_hit;
    bus.PHT_prediction_IF = if_base;
    bus.YAGS_prediction_IF = if_hit ? (if_base ? nt_ctr[1] : t_ctr[1]) : if_base;
    bus.pred_meta_IF = '{base_pred: if_base, cache_hit: if_hit, cache_idx: if_idx};
    bus.branch_count = br_cnt_q;
    bus.mispredict_count = mis_cnt_q;
  end
  always_comb begin
    ex_meta = bus.pred_meta_EX;
    ex_pht_idx = bus.pc_EX[PHT_IDX_BITS+1:2];
    ex_tag = bus.pc_EX[TAG_BITS+1:2];
    act = bus.actual_prediction;
    upd = bus.branch_signal && !bus.stall_EX;
    ex_ctr = ex_meta.base_pred ? nt_ex_ctr : t_ex_ctr;
    ex_yags = ex_meta.cache_hit ? ex_ctr[1] : ex_meta.base_pred;
    pht_wr = upd && !(ex_meta.cache_hit && (ex_yags == act) && (ex_meta.base_pred != act));
    pht_d = sat_ctr_update(pht_q[ex_pht_idx], act);
    cache_wr = upd && (ex_meta.cache_hit || (ex_meta.base_pred != act));
    ghr_d = upd ? {ghr_q[GHR_BITS-2:0], act} : ghr_q;
    br_cnt_d = (upd && !(&br_cnt_q)) ? br_cnt_q + 32'd1 : br_cnt_q;
    mis_cnt_d = (upd && (ex_yags != act) && !(&mis_cnt_q)) ? mis_cnt_q + 32'd1 : mis_cnt_q;
  end
  yags_tag_cache t_cache (
    .clk, .rst_n,
    .rd_idx(if_idx), .rd_tag(if_tag), .rd_hit(t_hit), .rd_ctr(t_ctr),
    .wr_en(cache_wr && !ex_meta.base_pred), .wr_alloc(!ex_meta.cache_hit),
    .wr_idx(ex_meta.cache_idx), .wr_tag(ex_tag), .wr_taken(act), .wr_ctr(t_ex_ctr)
  );
  yags_tag_cache nt_cache (
    .clk, .rst_n,
    .rd_idx(if_idx), .rd_tag(if_tag), .rd_hit(nt_hit), .rd_ctr(nt_ctr),
    .wr_en(cache_wr && ex_meta.base_pred), .wr_alloc(!ex_meta.cache_hit),
    .wr_idx(ex_meta.cache_idx), .wr_tag(ex_tag), .wr_taken(act), .wr_ctr(nt_ex_ctr)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_WNT;
      ghr_q <= '0;
      br_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (pht_wr) pht_q[ex_pht_idx] <= pht_d;
      ghr_q <= ghr_d;
      br_cnt_q <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
endmodule

// File: tb/tb_yags_branch_predictor.sv
// tb_yags_branch_predictor: vector table, directed corner sequences and randomized model check of the YAGS predictor
module tb_yags_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  yags_branch_predictor_if bus ();
  yags_branch_predictor dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    bit upd;
    logic [31:0] pc_ex;
    logic [9:0] meta;
    bit act;
    logic [31:0] pc_if;
    bit e_pht;
    bit e_yags;
    logic [9:0] e_meta;
    int e_br;
    int e_mis;
  } vec_t;
  vec_t tbl [10];
  int pht [1024];
  bit tv [256];
  bit nv [256];
  int tt [256];
  int ntg [256];
  int tc [256];
  int nc [256];
  int ghr;
  longint mbr, mmis;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic int sat(input int c, input bit t);
    return t ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
  endfunction
  function automatic void m_reset();
    for (int i = 0; i < 1024; i++) pht[i] = 1;
    for (int i = 0; i < 256; i++) begin
      tv[i] = 0;
      nv[i] = 0;
    end
    ghr = 0;
    mbr = 0;
    mmis = 0;
  endfunction
  function automatic void m_lookup(input int pc, output bit base, output bit hit, output int idx, output bit yags);
    int w, tag, c;
    w = pc >>> 2;
    base = pht[w % 1024] >= 2;
    idx = (w % 256) ^ ghr;
    tag = w % 64;
    hit = base ? (nv[idx] && ntg[idx] == tag) : (tv[idx] && tt[idx] == tag);
    c = base ? nc[idx] : tc[idx];
    yags = hit ? (c >= 2) : base;
  endfunction
  function automatic void m_update(input int pc, input bit base, input bit hit, input int idx, input bit act);
    int w, c;
    bit yags;
    w = pc >>> 2;
    c = base ? nc[idx] : tc[idx];
    yags = hit ? (c >= 2) : base;
    if (!(hit && yags == act && base != act)) pht[w % 1024] = sat(pht[w % 1024], act);
    if (hit || base != act) begin
      c = hit ? sat(c, act) : (act ? 2 : 1);
      if (base) begin
        nv[idx] = 1;
        ntg[idx] = w % 64;
        nc[idx] = c;
      end else begin
        tv[idx] = 1;
        tt[idx] = w % 64;
        tc[idx] = c;
      end
    end
    ghr = ((ghr << 1) | int'(act)) % 256;
    if (mbr < 64'hFFFF_FFFF) mbr++;
    if (yags != act && mmis < 64'hFFFF_FFFF) mmis++;
  endfunction
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_reset();
  endtask
  initial begin
    bit b, h, y, a, st, br;
    int ix;
    logic [31:0] pc;
    bus.pc_IF = '0;
    bus.branch_signal = 1'b0;
    bus.actual_prediction = 1'b0;
    bus.pc_EX = '0;
    bus.pred_meta_EX = '0;
    bus.stall_EX = 1'b0;
    tbl[0] = '{0, 32'h0, 10'h0, 0, 32'h100, 0, 0, 10'h040, 0, 0};
    tbl[1] = '{0, 32'h0, 10'h0, 0, 32'h3FC, 0, 0, 10'h0FF, 0, 0};
    tbl[2] = '{0, 32'h0, 10'h0, 0, 32'hFFFF_FFFC, 0, 0, 10'h0FF, 0, 0};
    tbl[3] = '{1, 32'h100, 10'h040, 1, 32'h100, 1, 1, 10'h241, 1, 1};
    tbl[4] = '{1, 32'h100, 10'h040, 1, 32'h100, 1, 1, 10'h243, 2, 2};
    tbl[5] = '{1, 32'h100, 10'h040, 1, 32'h100, 1, 1, 10'h247, 3, 3};
    tbl[6] = '{1, 32'h100, 10'h040, 1, 32'h100, 1, 1, 10'h24F, 4, 4};
    tbl[7] = '{1, 32'h100, 10'h25E, 0, 32'h100, 1, 0, 10'h35E, 5, 5};
    tbl[8] = '{1, 32'h100, 10'h35E, 0, 32'h100, 1, 1, 10'h27C, 6, 5};
    tbl[9] = '{1, 32'h100, 10'h35E, 1, 32'h100, 1, 1, 10'h239, 7, 6};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].upd) begin
        bus.pc_EX = tbl[i].pc_ex;
        bus.pred_meta_EX = tbl[i].meta;
        bus.actual_prediction = tbl[i].act;
        bus.branch_signal = 1'b1;
        tick();
        bus.branch_signal = 1'b0;
      end
      bus.pc_IF = tbl[i].pc_if;
      #1;
      chk($sformatf("vec%0d_pht", i), bus.PHT_prediction_IF, tbl[i].e_pht);
      chk($sformatf("vec%0d_yags", i), bus.YAGS_prediction_IF, tbl[i].e_yags);
      chk($sformatf("vec%0d_meta", i), bus.pred_meta_IF, tbl[i].e_meta);
      chk($sformatf("vec%0d_br", i), bus.branch_count, tbl[i].e_br);
      chk($sformatf("vec%0d_mis", i), bus.mispredict_count, tbl[i].e_mis);
    end
    do_reset();
    bus.pc_IF = 32'h100;
    bus.pc_EX = 32'h100;
    bus.pred_meta_EX = 10'h040;
    bus.actual_prediction = 1'b1;
    bus.branch_signal = 1'b1;
    #1;
    chk("same_cycle_old_pht", bus.PHT_prediction_IF, 0);
    chk("same_cycle_old_yags", bus.YAGS_prediction_IF, 0);
    tick();
    bus.branch_signal = 1'b0;
    #1;
    chk("same_cycle_new_pht", bus.PHT_prediction_IF, 1);
    chk("same_cycle_new_meta", bus.pred_meta_IF, 10'h241);
    bus.pred_meta_EX = 10'h241;
    bus.actual_prediction = 1'b0;
    bus.branch_signal = 1'b1;
    bus.stall_EX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_br", i), bus.branch_count, 1);
      chk($sformatf("stall%0d_mis", i), bus.mispredict_count, 1);
      chk($sformatf("stall%0d_meta", i), bus.pred_meta_IF, 10'h241);
      chk($sformatf("stall%0d_pht", i), bus.PHT_prediction_IF, 1);
    end
    bus.stall_EX = 1'b0;
    tick();
    bus.branch_signal = 1'b0;
    tick();
    chk("unstall_br", bus.branch_count, 2);
    chk("unstall_mis", bus.mispredict_count, 2);
    chk("unstall_pht", bus.PHT_prediction_IF, 0);
    chk("unstall_yags", bus.YAGS_prediction_IF, 0);
    chk("unstall_meta", bus.pred_meta_IF, 10'h042);
    force dut.br_cnt_q = 32'hFFFF_FFFF;
    force dut.mis_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt_q;
    release dut.mis_cnt_q;
    bus.pred_meta_EX = 10'h042;
    bus.actual_prediction = 1'b1;
    bus.branch_signal = 1'b1;
    tick();
    bus.branch_signal = 1'b0;
    #1;
    chk("sat_br", bus.branch_count, 32'hFFFF_FFFF);
    chk("sat_mis", bus.mispredict_count, 32'hFFFF_FFFF);
    bus.pred_meta_EX = 10'h040;
    bus.branch_signal = 1'b1;
    do_reset();
    bus.branch_signal = 1'b0;
    bus.pc_IF = 32'h100;
    #1;
    chk("rst_br", bus.branch_count, 0);
    chk("rst_mis", bus.mispredict_count, 0);
    chk("rst_pht", bus.PHT_prediction_IF, 0);
    chk("rst_yags", bus.YAGS_prediction_IF, 0);
    chk("rst_meta", bus.pred_meta_IF, 10'h040);
    bus.pc_IF = 32'h104;
    #1;
    chk("rst_meta2", bus.pred_meta_IF, 10'h041);
    for (int n = 0; n < 600; n++) begin
      pc = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 10);
      bus.pc_IF = pc;
      #1;
      m_lookup(int'(pc), b, h, ix, y);
      chk("rnd_pht", bus.PHT_prediction_IF, b);
      chk("rnd_yags", bus.YAGS_prediction_IF, y);
      chk("rnd_meta", bus.pred_meta_IF, {b, h, 8'(ix)});
      a = pc[2] ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 1);
      st = $urandom_range(0, 7) == 0;
      br = $urandom_range(0, 7) != 0;
      bus.pc_EX = pc;
      bus.pred_meta_EX = {b, h, 8'(ix)};
      bus.actual_prediction = a;
      bus.stall_EX = st;
      bus.branch_signal = br;
      bus.pc_IF = $urandom;
      tick();
      if (br && !st) m_update(int'(pc), b, h, ix, a);
      bus.branch_signal = 1'b0;
      bus.stall_EX = 1'b0;
      #1;
      chk("rnd_br", bus.branch_count, mbr);
      chk("rnd_mis", bus.mispredict_count, mmis);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
